multicycle_cu: RTL and testbench

MULTICYCLE_CU -- requirements
Module: multicycle_cu

---
 rtl/multicycle_cu.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_multicycle_cu.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cu.sv
// multicycle_cu -- control unit for a multicycle RV32I-style datapath.
//
// Walks each instruction through FETCH, DECODE, EXEC, MEM and WB. All
// datapath controls are decoded combinationally from the registered state,
// the instruction fields, the bus ready inputs and the ALU flags. Only
// trap_o and trap_cause_o are registered.
//
// Optional feature: define CU_TRAP_EN to enable illegal-instruction and
// bus-timeout traps. Without it, illegal instructions retire as NOPs, bus
// waits are unbounded, and trap_o/trap_cause_o are tied to 0.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   opcode_i/funct3_i/funct7_i instruction fields from the IR
//   imem_ready_i, dmem_ready_i instruction word valid / data access done
//   alu_zero_i, alu_lt_i      ALU result == 0 / ALU result bit 0
//   imem_req_o                instruction fetch request
//   ir_write_o, opc_write_o   load IR / latch current PC into old-PC reg
//   pc_write_o, pc_sel_o      PC update: 00 PC+4, 01 OPC+imm, 10 ALU&~1, 11 trap vector
//   regs_write_o              register file write
//   dm_read_o, dm_write_o     data memory read / write
//   alu_lhs_sel_o             0 A-reg, 1 OPC
//   alu_rhs_sel_o             0 B-reg, 1 immediate
//   alu_op_o                  0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND
//   wb_sel_o                  00 imm, 01 ALU, 10 MDR, 11 OPC+4
//   busy_o                    high whenever the unit is not idle
//   trap_o, trap_cause_o      trap strobe, cause 01 illegal / 10 bus error

module multicycle_cu #(
  parameter int MEM_TIMEOUT = 15,
  parameter int ALU_OP_W    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [6:0]          opcode_i,
  input  logic [2:0]          funct3_i,
  input  logic [6:0]          funct7_i,
  input  logic                imem_ready_i,
  input  logic                dmem_ready_i,
  input  logic                alu_zero_i,
  input  logic                alu_lt_i,
  output logic                imem_req_o,
  output logic                ir_write_o,
  output logic                opc_write_o,
  output logic                pc_write_o,
  output logic [1:0]          pc_sel_o,
  output logic                regs_write_o,
  output logic                dm_read_o,
  output logic                dm_write_o,
  output logic                alu_lhs_sel_o,
  output logic                alu_rhs_sel_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [1:0]          wb_sel_o,
  output logic                busy_o,
  output logic                trap_o,
  output logic [1:0]          trap_cause_o
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("multicycle_cu: MEM_TIMEOUT must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6f;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_REG   = 7'h33;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(9);

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_REL  = 2'b01;
  localparam logic [1:0] PC_ALU  = 2'b10;
  localparam logic [1:0] PC_TRAP = 2'b11;

  state_e state_q, state_d;

  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_load, is_store, is_imm, is_reg;
  logic legal, br_taken;
  logic [ALU_OP_W-1:0] arith_op, br_op;

  assign is_lui   = (opcode_i == OP_LUI);
  assign is_auipc = (opcode_i == OP_AUIPC);
  assign is_jal   = (opcode_i == OP_JAL);
  assign is_jalr  = (opcode_i == OP_JALR);
  assign is_br    = (opcode_i == OP_BR);
  assign is_load  = (opcode_i == OP_LOAD);
  assign is_store = (opcode_i == OP_STORE);
  assign is_imm   = (opcode_i == OP_IMM);
  assign is_reg   = (opcode_i == OP_REG);

  // funct7[5] selects SUB only for register forms; ADDI has immediate bits there.
  always_comb begin
    arith_op = ALU_ADD;
    case (funct3_i)
      3'b000:  arith_op = (is_reg && funct7_i[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = funct7_i[5] ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  // funct3[2] picks the signed/unsigned compare family; funct3[0] inverts the condition.
  assign br_op    = funct3_i[2] ? (funct3_i[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
  assign br_taken = (funct3_i[2] ? alu_lt_i : alu_zero_i) ^ funct3_i[0];

  always_comb begin
    legal = 1'b1;
    if (is_reg)
      legal = (funct7_i == 7'h00) ||
              ((funct7_i == 7'h20) && ((funct3_i == 3'b000) || (funct3_i == 3'b101)));
    else if (is_imm && funct3_i == 3'b001)
      legal = (funct7_i == 7'h00);
    else if (is_imm && funct3_i == 3'b101)
      legal = (funct7_i == 7'h00) || (funct7_i == 7'h20);
    else if (is_br)
      legal = (funct3_i[2:1] != 2'b01);
    else if (!(is_lui || is_auipc || is_jal || is_jalr || is_load || is_store || is_imm))
      legal = 1'b0;
  end

`ifdef CU_TRAP_EN
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  logic [7:0] wait_q, wait_d;
  logic       trap_q;
  logic [1:0] cause_q, cause_d;
`endif

  assign busy_o = (state_q != S_IDLE);

  always_comb begin
    state_d       = state_q;
    imem_req_o    = 1'b0;
    ir_write_o    = 1'b0;
    opc_write_o   = 1'b0;
    pc_write_o    = 1'b0;
    pc_sel_o      = PC_SEQ;
    regs_write_o  = 1'b0;
    dm_read_o     = 1'b0;
    dm_write_o    = 1'b0;
    alu_lhs_sel_o = 1'b0;
    alu_rhs_sel_o = 1'b0;
    alu_op_o      = ALU_ADD;
    wb_sel_o      = 2'b00;
`ifdef CU_TRAP_EN
    wait_d        = 8'd0;
    cause_d       = cause_q;
`endif
    // Strobes are suppressed while reset is asserted so an in-flight access is dropped.
    if (!rst_i) begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          imem_req_o = 1'b1;
          if (imem_ready_i) begin
            ir_write_o  = 1'b1;
            opc_write_o = 1'b1;
            pc_write_o  = 1'b1;
            pc_sel_o    = PC_SEQ;
            state_d     = S_DECODE;
          end
`ifdef CU_TRAP_EN
          else if (wait_q == WAIT_LAST) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
          end else begin
            wait_d = wait_q + 8'd1;
          end
`endif
        end
        S_DECODE: begin
          if (!legal) begin
`ifdef CU_TRAP_EN
            state_d = S_TRAP;
            cause_d = 2'b01;
`else
            state_d = S_FETCH;
`endif
          end else if (is_lui || is_jal) begin
            state_d = S_WB;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_reg) begin
            alu_op_o = arith_op;
          end else if (is_imm) begin
            alu_op_o      = arith_op;
            alu_rhs_sel_o = 1'b1;
          end else if (is_br) begin
            alu_op_o = br_op;
          end else begin
            // load/store/JALR address and AUIPC all add an immediate
            alu_rhs_sel_o = 1'b1;
            alu_lhs_sel_o = is_auipc;
          end
          if (is_load || is_store) begin
            state_d = S_MEM;
          end else if (is_br) begin
            state_d = S_FETCH;
            if (br_taken) begin
              pc_write_o = 1'b1;
              pc_sel_o   = PC_REL;
            end
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          dm_read_o  = is_load;
          dm_write_o = is_store;
          if (dmem_ready_i) begin
            state_d = is_load ? S_WB : S_FETCH;
          end
`ifdef CU_TRAP_EN
          else if (wait_q == WAIT_LAST) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
          end else begin
            wait_d = wait_q + 8'd1;
          end
`endif
        end
        S_WB: begin
          regs_write_o = 1'b1;
          if (is_lui)                 wb_sel_o = 2'b00;
          else if (is_load)           wb_sel_o = 2'b10;
          else if (is_jal || is_jalr) wb_sel_o = 2'b11;
          else                        wb_sel_o = 2'b01;
          if (is_jal || is_jalr) begin
            pc_write_o = 1'b1;
            pc_sel_o   = is_jal ? PC_REL : PC_ALU;
          end
          state_d = S_FETCH;
        end
        S_TRAP: begin
          pc_write_o = 1'b1;
          pc_sel_o   = PC_TRAP;
          state_d    = S_FETCH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

`ifdef CU_TRAP_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q  <= 8'd0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      wait_q  <= wait_d;
      trap_q  <= (state_d == S_TRAP);
      cause_q <= cause_d;
    end
  end

  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;
`else
  assign trap_o       = 1'b0;
  assign trap_cause_o = 2'b00;
`endif

endmodule

// File: tb/tb_multicycle_cu.sv
module tb_multicycle_cu;

  typedef struct packed {
    logic       busy;
    logic       imem_req;
    logic       ir_write;
    logic       opc_write;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       regs_write;
    logic       dm_read;
    logic       dm_write;
    logic       lhs;
    logic       rhs;
    logic [3:0] alu_op;
    logic [1:0] wb_sel;
    logic       trap;
    logic [1:0] cause;
  } obs_t;

  typedef struct {
    string      nm;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ir;
    logic       dr;
    logic       z;
    logic       lt;
    obs_t       exp;
    obs_t       msk;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       imem_ready, dmem_ready, alu_zero, alu_lt;
  logic       imem_req, ir_write, opc_write, pc_write, regs_write, dm_read, dm_write;
  logic       lhs, rhs, busy, trap;
  logic [1:0] pc_sel, wb_sel, trap_cause;
  logic [3:0] alu_op;
  obs_t       obs;

  int         checks = 0;
  int         errors = 0;
  ent_t       sb[$];
  logic [1:0] exp_cause = 2'b00;
  logic [6:0] cur_op = '0, cur_f7 = '0;
  logic [2:0] cur_f3 = '0;
  logic       cur_z = 1'b0, cur_lt = 1'b0;

  always #5 clk = ~clk;

  multicycle_cu #(.MEM_TIMEOUT(4), .ALU_OP_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
    .alu_zero_i(alu_zero), .alu_lt_i(alu_lt),
    .imem_req_o(imem_req), .ir_write_o(ir_write), .opc_write_o(opc_write),
    .pc_write_o(pc_write), .pc_sel_o(pc_sel), .regs_write_o(regs_write),
    .dm_read_o(dm_read), .dm_write_o(dm_write),
    .alu_lhs_sel_o(lhs), .alu_rhs_sel_o(rhs), .alu_op_o(alu_op),
    .wb_sel_o(wb_sel), .busy_o(busy), .trap_o(trap), .trap_cause_o(trap_cause)
  );

  assign obs = {busy, imem_req, ir_write, opc_write, pc_write, pc_sel, regs_write,
                dm_read, dm_write, lhs, rhs, alu_op, wb_sel, trap, trap_cause};

  function automatic obs_t st_base();
    obs_t e;
    e = '0;
    e.busy  = 1'b1;
    e.cause = exp_cause;
    return e;
  endfunction

  task automatic push(string nm, logic ir, logic dr, obs_t e, bit ex);
    ent_t t;
    obs_t m;
    m = '0;
    m.busy = 1; m.imem_req = 1; m.ir_write = 1; m.opc_write = 1; m.pc_write = 1;
    m.regs_write = 1; m.dm_read = 1; m.dm_write = 1; m.trap = 1; m.cause = 2'b11;
    if (e.pc_write)   m.pc_sel = 2'b11;
    if (e.regs_write) m.wb_sel = 2'b11;
    if (ex) begin m.alu_op = 4'hf; m.lhs = 1; m.rhs = 1; end
    t.nm = nm; t.op = cur_op; t.f3 = cur_f3; t.f7 = cur_f7;
    t.ir = ir; t.dr = dr; t.z = cur_z; t.lt = cur_lt;
    t.exp = e; t.msk = m;
    sb.push_back(t);
  endtask

  task automatic push_fetch(string nm, int fwaits);
    obs_t e;
    for (int i = 0; i < fwaits; i++) begin
      e = st_base(); e.imem_req = 1;
      push({nm, ":fetch_wait"}, 1'b0, 1'b0, e, 0);
    end
    e = st_base();
    e.imem_req = 1; e.ir_write = 1; e.opc_write = 1; e.pc_write = 1; e.pc_sel = 2'b00;
    push({nm, ":fetch"}, 1'b1, 1'b0, e, 0);
  endtask

  // Expected per-cycle sequence of one legal instruction.
  task automatic push_instr(string nm, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                            logic z, logic lt, logic [3:0] e_alu, logic e_lhs, logic e_rhs,
                            logic e_taken, int fwaits, int mwaits);
    obs_t e;
    bit   is_l, is_s, is_b, is_lui, is_jal, is_jalr;
    is_l = (op == 7'h03); is_s = (op == 7'h23); is_b = (op == 7'h63);
    is_lui = (op == 7'h37); is_jal = (op == 7'h6f); is_jalr = (op == 7'h67);
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z; cur_lt = lt;
    push_fetch(nm, fwaits);
    push({nm, ":decode"}, 1'b1, 1'b0, st_base(), 0);
    if (!(is_lui || is_jal)) begin
      e = st_base(); e.alu_op = e_alu; e.lhs = e_lhs; e.rhs = e_rhs;
      if (is_b && e_taken) begin e.pc_write = 1; e.pc_sel = 2'b01; end
      push({nm, ":exec"}, 1'b1, 1'b0, e, 1);
    end
    if (is_l || is_s) begin
      for (int i = 0; i <= mwaits; i++) begin
        e = st_base(); e.dm_read = is_l; e.dm_write = is_s;
        push({nm, ":mem"}, 1'b1, (i == mwaits), e, 0);
      end
    end
    if (!(is_b || is_s)) begin
      e = st_base(); e.regs_write = 1;
      e.wb_sel = is_lui ? 2'b00 : is_l ? 2'b10 : (is_jal || is_jalr) ? 2'b11 : 2'b01;
      if (is_jal || is_jalr) begin e.pc_write = 1; e.pc_sel = is_jal ? 2'b01 : 2'b10; end
      push({nm, ":wb"}, 1'b1, 1'b0, e, 0);
    end
  endtask

  task automatic push_illegal(string nm, logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
    obs_t e;
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = 0; cur_lt = 0;
    push_fetch(nm, 0);
    push({nm, ":decode"}, 1'b1, 1'b0, st_base(), 0);
`ifdef CU_TRAP_EN
    exp_cause = 2'b01;
    e = st_base(); e.pc_write = 1; e.pc_sel = 2'b11; e.trap = 1;
    push({nm, ":trap"}, 1'b1, 1'b0, e, 0);
`else
    e = '0;
`endif
  endtask

  task automatic test_reset();
    ent_t t;
    obs_t zero_o;
    zero_o = '0;
    rst = 1; opcode = 7'h33; funct3 = 0; funct7 = 0;
    imem_ready = 1; dmem_ready = 1; alu_zero = 0; alu_lt = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== zero_o) begin
        errors++;
        $display("FAIL reset_hold[%0d] got=%h exp=%h", i, obs, zero_o);
      end
      @(posedge clk); #1;
    end
    rst = 0; exp_cause = 2'b00;
    cur_op = 7'h33; cur_f3 = 0; cur_f7 = 0; cur_z = 0; cur_lt = 0;
    push("idle", 1'b1, 1'b0, zero_o, 0);
    push_instr("add", 7'h33, 3'd0, 7'h00, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    push_instr("add2", 7'h33, 3'd0, 7'h00, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      opcode = t.op; funct3 = t.f3; funct7 = t.f7;
      imem_ready = t.ir; dmem_ready = t.dr; alu_zero = t.z; alu_lt = t.lt;
      @(negedge clk);
      checks++;
      if ((obs & t.msk) !== (t.exp & t.msk)) begin
        errors++;
        $display("FAIL %s got=%h exp=%h mask=%h", t.nm, obs & t.msk, t.exp & t.msk, t.msk);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_ops();
    ent_t t;
    push_instr("sub",       7'h33, 3'd0, 7'h20, 0, 0, 4'd1, 0, 0, 0, 0, 0);
    push_instr("sll",       7'h33, 3'd1, 7'h00, 0, 0, 4'd2, 0, 0, 0, 0, 0);
    push_instr("sra",       7'h33, 3'd5, 7'h20, 0, 0, 4'd7, 0, 0, 0, 0, 0);
    push_instr("srl",       7'h33, 3'd5, 7'h00, 0, 0, 4'd6, 0, 0, 0, 0, 0);
    push_instr("sltu",      7'h33, 3'd3, 7'h00, 0, 0, 4'd4, 0, 0, 0, 0, 0);
    push_instr("or",        7'h33, 3'd6, 7'h00, 0, 0, 4'd8, 0, 0, 0, 0, 0);
    push_instr("and",       7'h33, 3'd7, 7'h00, 0, 0, 4'd9, 0, 0, 0, 0, 0);
    push_instr("addi_f7",   7'h13, 3'd0, 7'h20, 0, 0, 4'd0, 0, 1, 0, 0, 0);
    push_instr("srai",      7'h13, 3'd5, 7'h20, 0, 0, 4'd7, 0, 1, 0, 0, 0);
    push_instr("slti",      7'h13, 3'd2, 7'h7f, 0, 0, 4'd3, 0, 1, 0, 0, 0);
    push_instr("xori_wait", 7'h13, 3'd4, 7'h55, 0, 0, 4'd5, 0, 1, 0, 2, 0);
    push_instr("lui",       7'h37, 3'd3, 7'h11, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    push_instr("auipc",     7'h17, 3'd1, 7'h2a, 0, 0, 4'd0, 1, 1, 0, 0, 0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      opcode = t.op; funct3 = t.f3; funct7 = t.f7;
      imem_ready = t.ir; dmem_ready = t.dr; alu_zero = t.z; alu_lt = t.lt;
      @(negedge clk);
      checks++;
      if ((obs & t.msk) !== (t.exp & t.msk)) begin
        errors++;
        $display("FAIL %s got=%h exp=%h mask=%h", t.nm, obs & t.msk, t.exp & t.msk, t.msk);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_access();
    ent_t t;
    push_instr("lw_wait3", 7'h03, 3'd2, 7'h00, 0, 0, 4'd0, 0, 1, 0, 0, 3);
    push_instr("sw",       7'h23, 3'd2, 7'h00, 0, 0, 4'd0, 0, 1, 0, 0, 0);
    push_instr("lb",       7'h03, 3'd0, 7'h7f, 0, 0, 4'd0, 0, 1, 0, 0, 0);
    push_instr("sw_wait2", 7'h23, 3'd2, 7'h00, 0, 0, 4'd0, 0, 1, 0, 0, 2);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      opcode = t.op; funct3 = t.f3; funct7 = t.f7;
      imem_ready = t.ir; dmem_ready = t.dr; alu_zero = t.z; alu_lt = t.lt;
      @(negedge clk);
      checks++;
      if ((obs & t.msk) !== (t.exp & t.msk)) begin
        errors++;
        $display("FAIL %s got=%h exp=%h mask=%h", t.nm, obs & t.msk, t.exp & t.msk, t.msk);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branches();
    ent_t t;
    push_instr("bne_taken", 7'h63, 3'd1, 7'h00, 0, 0, 4'd1, 0, 0, 1, 0, 0);
    push_instr("bne_not",   7'h63, 3'd1, 7'h00, 1, 0, 4'd1, 0, 0, 0, 0, 0);
    push_instr("beq_taken", 7'h63, 3'd0, 7'h00, 1, 0, 4'd1, 0, 0, 1, 0, 0);
    push_instr("beq_not",   7'h63, 3'd0, 7'h00, 0, 1, 4'd1, 0, 0, 0, 0, 0);
    push_instr("blt_taken", 7'h63, 3'd4, 7'h00, 0, 1, 4'd3, 0, 0, 1, 0, 0);
    push_instr("bge_taken", 7'h63, 3'd5, 7'h00, 1, 0, 4'd3, 0, 0, 1, 0, 0);
    push_instr("bltu_not",  7'h63, 3'd6, 7'h00, 1, 0, 4'd4, 0, 0, 0, 0, 0);
    push_instr("bgeu_not",  7'h63, 3'd7, 7'h00, 0, 1, 4'd4, 0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      opcode = t.op; funct3 = t.f3; funct7 = t.f7;
      imem_ready = t.ir; dmem_ready = t.dr; alu_zero = t.z; alu_lt = t.lt;
      @(negedge clk);
      checks++;
      if ((obs & t.msk) !== (t.exp & t.msk)) begin
        errors++;
        $display("FAIL %s got=%h exp=%h mask=%h", t.nm, obs & t.msk, t.exp & t.msk, t.msk);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jumps();
    ent_t t;
    push_instr("jal",  7'h6f, 3'd5, 7'h33, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    push_instr("jalr", 7'h67, 3'd0, 7'h00, 0, 0, 4'd0, 0, 1, 0, 0, 0);
    push_instr("jal2", 7'h6f, 3'd0, 7'h00, 1, 1, 4'd0, 0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      opcode = t.op; funct3 = t.f3; funct7 = t.f7;
      imem_ready = t.ir; dmem_ready = t.dr; alu_zero = t.z; alu_lt = t.lt;
      @(negedge clk);
      checks++;
      if ((obs & t.msk) !== (t.exp & t.msk)) begin
        errors++;
        $display("FAIL %s got=%h exp=%h mask=%h", t.nm, obs & t.msk, t.exp & t.msk, t.msk);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_waits_and_traps();
    ent_t t;
    obs_t e;
    push_illegal("op7f",       7'h7f, 3'd0, 7'h00);
    push_instr("add_after_ill", 7'h33, 3'd0, 7'h00, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    push_illegal("sub_bad_f3", 7'h33, 3'd1, 7'h20);
    push_illegal("slli_bad",   7'h13, 3'd1, 7'h20);
    push_illegal("br_f3_010",  7'h63, 3'd2, 7'h00);
    push_illegal("br_f3_011",  7'h63, 3'd3, 7'h00);
    cur_op = 7'h33; cur_f3 = 0; cur_f7 = 0; cur_z = 0; cur_lt = 0;
`ifdef CU_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      e = st_base(); e.imem_req = 1;
      push("timeout:fetch_wait", 1'b0, 1'b0, e, 0);
    end
    exp_cause = 2'b10;
    e = st_base(); e.pc_write = 1; e.pc_sel = 2'b11; e.trap = 1;
    push("timeout:trap", 1'b0, 1'b0, e, 0);
    push_instr("add_after_to", 7'h33, 3'd0, 7'h00, 0, 0, 4'd0, 0, 0, 0, 0, 0);
`else
    e = '0;
    push_instr("slow_fetch", 7'h33, 3'd0, 7'h00, 0, 0, 4'd0, 0, 0, 0, 12, 0);
    push_instr("slow_lw",    7'h03, 3'd2, 7'h00, 0, 0, 4'd0, 0, 1, 0, 0, 10);
`endif
    while (sb.size() > 0) begin
      t = sb.pop_front();
      opcode = t.op; funct3 = t.f3; funct7 = t.f7;
      imem_ready = t.ir; dmem_ready = t.dr; alu_zero = t.z; alu_lt = t.lt;
      @(negedge clk);
      checks++;
      if ((obs & t.msk) !== (t.exp & t.msk)) begin
        errors++;
        $display("FAIL %s got=%h exp=%h mask=%h", t.nm, obs & t.msk, t.exp & t.msk, t.msk);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mem();
    ent_t t;
    obs_t zero_o;
    zero_o = '0;
    // SW that would wait 5 cycles; reset lands on its second MEM cycle.
    push_instr("sw_abort", 7'h23, 3'd2, 7'h00, 0, 0, 4'd0, 0, 1, 0, 0, 5);
    while (sb.size() > 5) begin
      t = sb.pop_front();
      opcode = t.op; funct3 = t.f3; funct7 = t.f7;
      imem_ready = t.ir; dmem_ready = t.dr; alu_zero = t.z; alu_lt = t.lt;
      @(negedge clk);
      checks++;
      if ((obs & t.msk) !== (t.exp & t.msk)) begin
        errors++;
        $display("FAIL %s got=%h exp=%h mask=%h", t.nm, obs & t.msk, t.exp & t.msk, t.msk);
      end
      @(posedge clk); #1;
    end
    sb.delete();
    rst = 1; dmem_ready = 0;
    @(negedge clk);
    checks++;
    if (dm_write !== 1'b0 || dm_read !== 1'b0 || regs_write !== 1'b0 || imem_req !== 1'b0 ||
        pc_write !== 1'b0 || ir_write !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_mem got dm_write=%b dm_read=%b regs_write=%b imem_req=%b pc_write=%b ir_write=%b busy=%b exp 0 0 0 0 0 0 1",
               dm_write, dm_read, regs_write, imem_req, pc_write, ir_write, busy);
    end
    @(posedge clk); #1;
    rst = 0; exp_cause = 2'b00;
    cur_op = 7'h23; cur_f3 = 3'd2; cur_f7 = 0; cur_z = 0; cur_lt = 0;
    push("post_rst_idle", 1'b1, 1'b1, zero_o, 0);
    push_instr("add_post_rst", 7'h33, 3'd0, 7'h00, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      opcode = t.op; funct3 = t.f3; funct7 = t.f7;
      imem_ready = t.ir; dmem_ready = t.dr; alu_zero = t.z; alu_lt = t.lt;
      @(negedge clk);
      checks++;
      if ((obs & t.msk) !== (t.exp & t.msk)) begin
        errors++;
        $display("FAIL %s got=%h exp=%h mask=%h", t.nm, obs & t.msk, t.exp & t.msk, t.msk);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_mem_access();
    test_branches();
    test_jumps();
    test_waits_and_traps();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
